// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: consumer request, synchronized write pointer,
// and the read pointer / status values produced by fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 6
);
  localparam int PW = ADDR_WIDTH + 1;

  // Handshake: rd_en is the consumer's request (valid); the FIFO is "ready"
  // when empty=0. A word transfers in a cycle iff rd_fire = rd_en & ~empty,
  // and the data at raddr is the word consumed in that cycle.
  logic                  rd_en;
  logic [PW-1:0]         rq2_wptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [PW-1:0]         rptr;
  logic                  rd_fire;
  logic                  empty;
  logic                  almost_empty;
  logic [PW-1:0]         rd_count;
  logic                  underflow;

  modport master (
    output rd_en, rq2_wptr,
    input  raddr, rptr, rd_fire, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  rd_en, rq2_wptr,
    output raddr, rptr, rd_fire, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain control of the async FIFO: binary/Gray read pointer, empty,
// almost_empty, occupancy count and underflow pulse.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH    = 6,
  parameter int AEMPTY_THRESH = 4
) (
  input logic           clk,
  input logic           rst_n,
  fifo_rd_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] count_next;

  assign bus.rd_fire = bus.rd_en & ~bus.empty;

  assign rbin_next  = rbin + PW'(bus.rd_fire);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Each binary bit is the XOR of all Gray bits at or above it; every sample
  // is decoded on its own, so multi-step jumps of the write pointer are fine.
  for (genvar i = 0; i < PW; i++) begin : g_gray2bin
    assign wbin[i] = ^(bus.rq2_wptr >> i);
  end

  // The extra pointer MSB makes a full FIFO read as 2^ADDR_WIDTH, not 0.
  assign count_next = wbin - rbin_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin             <= '0;
      bus.rptr         <= '0;
      bus.raddr        <= '0;
      bus.empty        <= 1'b1;
      bus.almost_empty <= 1'b1;
      bus.rd_count     <= '0;
      bus.underflow    <= 1'b0;
    end else begin
      rbin             <= rbin_next;
      bus.rptr         <= rgray_next;
      bus.raddr        <= rbin_next[ADDR_WIDTH-1:0];
      bus.empty        <= (rgray_next == bus.rq2_wptr);
      bus.almost_empty <= (count_next <= AE_TH);
      bus.rd_count     <= count_next;
      bus.underflow    <= bus.rd_en & bus.empty;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: vector table, hand-written corner sequences and a
// randomized run checked against a word-counting reference model.
module tb_fifo_rd_ctrl;
  localparam int AW = 6;
  localparam int PW = AW + 1;

  logic clk;
  logic rst_n;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of words written and read since reset.
  int w_total;
  int r_total;
  bit m_empty;

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % (1 << PW));
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    w_total = 0;
    r_total = 0;
    m_empty = 1'b1;
  endtask

  // One clock: apply inputs, check the combinational strobe, then registers.
  task automatic model_cycle(input logic en, input int wstep);
    bit fire;
    bit was_empty;
    int occ;
    w_total += wstep;
    bus.rd_en    = en;
    bus.rq2_wptr = to_gray(w_total);
    #1;
    was_empty = m_empty;
    fire = en && !was_empty;
    chk("m_rd_fire", 32'(bus.rd_fire), 32'(fire));
    @(posedge clk);
    #1;
    if (fire) r_total++;
    occ = w_total - r_total;
    m_empty = (occ == 0);
    exp_q.push_back(32'(occ));
    chk("m_raddr", 32'(bus.raddr), 32'(r_total % (1 << AW)));
    chk("m_rptr", 32'(bus.rptr), 32'(to_gray(r_total)));
    chk("m_empty", 32'(bus.empty), 32'(m_empty));
    chk("m_almost_empty", 32'(bus.almost_empty), 32'(occ <= 4));
    chk("m_rd_count", 32'(bus.rd_count), exp_q.pop_front());
    chk("m_underflow", 32'(bus.underflow), 32'(en && was_empty));
  endtask

  // Asserts reset away from any clock edge and checks it acts immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'd1);
    chk({tag, "_raddr"}, 32'(bus.raddr), 32'd0);
    chk({tag, "_rptr"}, 32'(bus.rptr), 32'd0);
    chk({tag, "_rd_count"}, 32'(bus.rd_count), 32'd0);
    chk({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
    bus.rd_en    = 1'b0;
    bus.rq2_wptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic          rd_en;
    logic [PW-1:0] wptr;
    logic          fire;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          ae;
    logic [PW-1:0] cnt;
    logic          uf;
  } vec_t;

  vec_t vecs[6];

  bit saw_msb;
  bit saw_wrap;

  initial begin
    // fill to 3 words, drain 3, then one read on empty
    vecs[0] = '{1'b0, 7'b0000010, 1'b0, 6'd0, 7'b0000000, 1'b0, 1'b1, 7'd3, 1'b0};
    vecs[1] = '{1'b1, 7'b0000010, 1'b1, 6'd1, 7'b0000001, 1'b0, 1'b1, 7'd2, 1'b0};
    vecs[2] = '{1'b1, 7'b0000010, 1'b1, 6'd2, 7'b0000011, 1'b0, 1'b1, 7'd1, 1'b0};
    vecs[3] = '{1'b1, 7'b0000010, 1'b1, 6'd3, 7'b0000010, 1'b1, 1'b1, 7'd0, 1'b0};
    vecs[4] = '{1'b1, 7'b0000010, 1'b0, 6'd3, 7'b0000010, 1'b1, 1'b1, 7'd0, 1'b1};
    vecs[5] = '{1'b0, 7'b0000010, 1'b0, 6'd3, 7'b0000010, 1'b1, 1'b1, 7'd0, 1'b0};

    rst_n        = 1'b1;
    bus.rd_en    = 1'b0;
    bus.rq2_wptr = '0;
    model_reset();

    do_reset("reset1");
    chk("reset1_hold_empty", 32'(bus.empty), 32'd1);
    chk("reset1_hold_rd_count", 32'(bus.rd_count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus.rd_en    = vecs[i].rd_en;
      bus.rq2_wptr = vecs[i].wptr;
      #1;
      chk($sformatf("vec%0d_rd_fire", i), 32'(bus.rd_fire), 32'(vecs[i].fire));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_raddr", i), 32'(bus.raddr), 32'(vecs[i].raddr));
      chk($sformatf("vec%0d_rptr", i), 32'(bus.rptr), 32'(vecs[i].rptr));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_almost_empty", i), 32'(bus.almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d_rd_count", i), 32'(bus.rd_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_underflow", i), 32'(bus.underflow), 32'(vecs[i].uf));
    end

    // Full level: 64 words visible with the read pointer at 0.
    do_reset("reset2");
    bus.rq2_wptr = 7'b1100000;
    @(posedge clk);
    #1;
    chk("full_rd_count", 32'(bus.rd_count), 32'd64);
    chk("full_almost_empty", 32'(bus.almost_empty), 32'd0);
    chk("full_empty", 32'(bus.empty), 32'd0);

    // Last word read in the same cycle a new write becomes visible.
    do_reset("reset3");
    bus.rq2_wptr = 7'b0000001;
    @(posedge clk);
    #1;
    chk("last_pre_rd_count", 32'(bus.rd_count), 32'd1);
    bus.rd_en    = 1'b1;
    bus.rq2_wptr = 7'b0000011;
    #1;
    chk("last_rd_fire", 32'(bus.rd_fire), 32'd1);
    @(posedge clk);
    #1;
    chk("last_empty", 32'(bus.empty), 32'd0);
    chk("last_rd_count", 32'(bus.rd_count), 32'd1);
    chk("last_raddr", 32'(bus.raddr), 32'd1);
    bus.rd_en = 1'b0;

    // Wrap: 130 writes, consumer reads whenever data is available.
    do_reset("reset4");
    saw_msb  = 1'b0;
    saw_wrap = 1'b0;
    for (int c = 0; c < 400 && !(w_total == 130 && m_empty); c++) begin
      int step;
      step = (w_total < 130) ? int'($urandom_range(0, 2)) : 0;
      if (w_total + step > 130) step = 130 - w_total;
      model_cycle(!m_empty, step);
      if (bus.rptr == 7'b1000000) saw_msb = 1'b1;
      if (saw_msb && bus.rptr == 7'b0000000) saw_wrap = 1'b1;
    end
    chk("wrap_rptr_msb_seen", 32'(saw_msb), 32'd1);
    chk("wrap_rptr_zero_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_final_empty", 32'(bus.empty), 32'd1);
    chk("wrap_final_rd_count", 32'(bus.rd_count), 32'd0);
    chk("wrap_final_raddr", 32'(bus.raddr), 32'(130 % 64));

    // Random traffic, including bursts to full and reads on empty.
    for (int c = 0; c < 600; c++) begin
      int step;
      int room;
      room = 64 - (w_total - r_total);
      step = int'($urandom_range(0, 3));
      if (step > room) step = room;
      model_cycle(1'($urandom_range(0, 1)), step);
    end

    // Reset in the middle of traffic returns everything to idle.
    model_cycle(1'b0, 5);
    do_reset("reset5");
    chk("reset5_hold_empty", 32'(bus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
